exe_lsu_stage: RTL and testbench
================================

# exe_lsu_stage

Parametrised execute stage with a handshaked data-memory request port. It sits between decode and memory stages: it latches the decode payload, computes the effective address, and checks alignment. For loads/stores it issues one request on a req/addr_ok SRAM-like bus and holds the instruction until the request is accepted. It supports 32- or 64-bit data paths, pipeline flush, and discard of in-flight requests.

## Interface
Parameters:
- DATA_W, 32, data bus width; legal values 32 or 64.
- PAYLOAD_W, 70, opaque decode→mem payload passed through unchanged.
- Derived: STRB_W = DATA_W/8; OFF_W = log2(STRB_W).

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high.
- ds_to_es_valid  in  1  decode entry valid.
- es_allowin  out  1  stage can accept an entry this cycle.
- ds_mem_en / ds_mem_we  in  1/1  memory op / store.
- ds_mem_size  in  2  0=byte, 1=half, 2=word, 3=dword (dword legal only when DATA_W=64).
- ds_base, ds_offset  in  32/32  address operands; offset is already sign-extended.
- ds_st_data  in  DATA_W  store source, low-aligned.
- ds_payload  in  PAYLOAD_W  passthrough.
- flush  in  1  kill the current entry.
- ms_allowin  in  1  memory stage ready.
- es_to_ms_valid  out  1.
- es_to_ms_bus  out  PAYLOAD_W+32+4  {payload, addr, ale, ghost, mem_en, mem_we}.
- data_sram_req  out  1; data_sram_wr  out  1; data_sram_size  out  2; data_sram_wstrb  out  STRB_W; data_sram_addr  out  32; data_sram_wdata  out  DATA_W.
- data_sram_addr_ok  in  1.

## Operation
- The entry register captures all ds_* inputs when ds_to_es_valid && es_allowin.
- Address: addr = base + offset, modulo 2^32.
- ale is set when an access is misaligned:
  - half with addr[0] set;
  - word with addr[1:0] ≠ 0;
  - dword with addr[2:0] ≠ 0;
  - size 3 when DATA_W=32.
- An ale entry issues no request and is forwarded with ale=1.
- wstrb = base mask shifted left by addr[OFF_W-1:0]. Base masks: byte 0x1, half 0x3, word 0xF, dword 0xFF. Loads drive wstrb = 0.
- wdata: the low 8/16/32 bits are replicated across DATA_W; a dword store passes ds_st_data unchanged.
- FSM (per entry):
  - IDLE: no valid entry.
  - REQ: mem op, not ale, not yet accepted; data_sram_req = 1.
  - ACC: request accepted; waiting for ms_allowin.
  - FWD: non-mem or ale entry; waiting for ms_allowin.
- Transitions:
  - Capture goes to REQ or FWD.
  - REQ goes to ACC when addr_ok && !ms_allowin.
  - REQ, ACC, or FWD with a handoff loads the next entry, or goes to IDLE.
- es_ready_go = FWD | ACC | (REQ & addr_ok).
- es_allowin = IDLE | (es_ready_go & ms_allowin).
- Flush:
  - In IDLE, FWD, or REQ without addr_ok the same cycle: drop the entry (go to IDLE). No request is issued that cycle; req is gated by !flush.
  - In ACC, or REQ with addr_ok the same cycle: the request cannot be retracted. The entry becomes a ghost (ghost=1) and is forwarded normally so the memory stage drains and discards the response.
  - A later flush on a ghost has no further effect.
- No new entry is captured in a flush cycle.

## Timing
- Reset values: es_valid 0 (state IDLE), es_to_ms_valid 0, data_sram_req 0. All bus outputs are 0.
- data_sram_* outputs are driven from the entry register only, never combinationally from ds_*. They are stable while req=1.
- req is held until addr_ok. At most one request is accepted per entry, and req drops in the cycle after acceptance.
- Minimum latency is 1 cycle in EXE: a capture at edge N can hand off at edge N+1 if addr_ok and ms_allowin are both 1 in that cycle.
- Back-to-back mem ops sustain 1 per cycle under continuous addr_ok.
- Reset mid-request: req drops the following cycle and no ghost is produced. The bus side is reset with the core.

## Structure
- Shared package lsu_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - FSM state enum;
  - to-ms bus field offsets.
- One natural sub-module: lsu_align (combinational). It produces ale, wstrb and the replicated wdata from size, addr, and data. It is reused later by the memory-stage load extractor.

## Test plan
- Store word, DATA_W=32, base 0x1000, offset 4, data 0xA5A5_1234, addr_ok in the first cycle: req=1, addr 0x1004, wstrb 0xF, wdata 0xA5A51234; handoff next edge.
- Store byte to addr 0x1003 with data 0x77: wstrb 0x8, wdata 0x77777777. With DATA_W=64 at addr 0x1005: wstrb 0x20.
- Load half at 0x2001: no req, ale=1, forwarded in 1 cycle; es_to_ms_bus addr field = 0x2001.
- Load with addr_ok delayed 3 cycles: req high and addr stable for 4 cycles, es_allowin=0 throughout; a single acceptance.
- Flush while in REQ with addr_ok=0: entry dropped, req=0 the next cycle, nothing forwarded. Flush in ACC with ms_allowin=0: the entry is forwarded later with ghost=1.
- Reset asserted in REQ: the next cycle es_to_ms_valid=0, req=0, es_allowin=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: definitions shared by the execute-stage LSU and its helpers.
//   - SZ_B/SZ_H/SZ_W/SZ_D : access size encodings (1/2/4/8 bytes)
//   - es_state_e          : per-entry state of the execute stage
//   - BUS_*               : bit offsets of the fields in es_to_ms_bus
//                           {payload, addr, ale, ghost, mem_en, mem_we}
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no valid entry
    ST_REQ  = 2'd1,  // memory request outstanding on the bus
    ST_ACC  = 2'd2,  // request accepted, waiting for the memory stage
    ST_FWD  = 2'd3   // no request needed, waiting for the memory stage
  } es_state_e;

  // Field positions inside es_to_ms_bus (LSB of each field).
  localparam int BUS_WE      = 0;
  localparam int BUS_EN      = 1;
  localparam int BUS_GHOST   = 2;
  localparam int BUS_ALE     = 3;
  localparam int BUS_ADDR    = 4;
  localparam int BUS_PAYLOAD = 36;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational alignment helper.
//   size    : access size (SZ_B..SZ_D)
//   addr_lo : low three address bits
//   data    : store data, low-aligned
//   ale     : access is misaligned (or dword on a 32-bit datapath)
//   wstrb   : byte-lane mask for the access, shifted to its lane
//   wdata   : store data replicated across all byte lanes
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]          size,
  input  logic [2:0]          addr_lo,
  input  logic [DATA_W-1:0]   data,
  output logic                ale,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   wdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  logic [STRB_W-1:0] mask;

  always_comb begin
    mask  = '0;
    ale   = 1'b0;
    wdata = data;
    case (size)
      SZ_B: begin
        mask  = STRB_W'(8'h01);
        wdata = {(DATA_W/8){data[7:0]}};
      end
      SZ_H: begin
        mask  = STRB_W'(8'h03);
        ale   = addr_lo[0];
        wdata = {(DATA_W/16){data[15:0]}};
      end
      SZ_W: begin
        mask  = STRB_W'(8'h0F);
        ale   = (addr_lo[1:0] != 2'b00);
        wdata = {(DATA_W/32){data[31:0]}};
      end
      default: begin
        // A dword cannot be carried by a 32-bit datapath at all.
        mask  = STRB_W'(8'hFF);
        ale   = (addr_lo != 3'b000) || (DATA_W == 32);
        wdata = data;
      end
    endcase
  end

  assign wstrb = mask << addr_lo[OFF_W-1:0];

endmodule

// File: rtl/exe_lsu_stage.sv
// exe_lsu_stage: execute stage with a req/addr_ok data-memory request port.
//   decode side : ds_to_es_valid / es_allowin handshake, ds_* entry fields
//   mem side    : es_to_ms_valid / ms_allowin handshake, es_to_ms_bus
//   sram side   : data_sram_req/wr/size/wstrb/addr/wdata, data_sram_addr_ok
//   control     : flush kills the current entry, reset is synchronous
// The effective address, alignment result, strobe and replicated store data
// are computed at capture time and held in the entry register, so every
// data_sram_* output comes straight from a flop and stays stable under req.
module exe_lsu_stage
  import lsu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 70
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ds_to_es_valid,
  output logic                    es_allowin,
  input  logic                    ds_mem_en,
  input  logic                    ds_mem_we,
  input  logic [1:0]              ds_mem_size,
  input  logic [31:0]             ds_base,
  input  logic [31:0]             ds_offset,
  input  logic [DATA_W-1:0]       ds_st_data,
  input  logic [PAYLOAD_W-1:0]    ds_payload,
  input  logic                    flush,
  input  logic                    ms_allowin,
  output logic                    es_to_ms_valid,
  output logic [PAYLOAD_W+35:0]   es_to_ms_bus,
  output logic                    data_sram_req,
  output logic                    data_sram_wr,
  output logic [1:0]              data_sram_size,
  output logic [DATA_W/8-1:0]     data_sram_wstrb,
  output logic [31:0]             data_sram_addr,
  output logic [DATA_W-1:0]       data_sram_wdata,
  input  logic                    data_sram_addr_ok
);

  localparam int STRB_W = DATA_W / 8;

  es_state_e              state_q,   state_d;
  logic                   ghost_q,   ghost_d;
  logic                   mem_en_q,  mem_en_d;
  logic                   mem_we_q,  mem_we_d;
  logic                   ale_q,     ale_d;
  logic [1:0]             size_q,    size_d;
  logic [31:0]            addr_q,    addr_d;
  logic [STRB_W-1:0]      wstrb_q,   wstrb_d;
  logic [DATA_W-1:0]      wdata_q,   wdata_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;

  logic [31:0]            ds_addr;
  logic                   ds_ale_raw;
  logic [STRB_W-1:0]      ds_wstrb;
  logic [DATA_W-1:0]      ds_wdata;

  logic es_ready_go, handoff, drop, make_ghost, capture;

  assign ds_addr = ds_base + ds_offset;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .size    (ds_mem_size),
    .addr_lo (ds_addr[2:0]),
    .data    (ds_st_data),
    .ale     (ds_ale_raw),
    .wstrb   (ds_wstrb),
    .wdata   (ds_wdata)
  );

  always_comb begin
    es_ready_go = (state_q == ST_FWD) || (state_q == ST_ACC) ||
                  ((state_q == ST_REQ) && data_sram_addr_ok);
    handoff     = es_ready_go && ms_allowin;
    es_allowin  = (state_q == ST_IDLE) || handoff;
    // Nothing has reached the bus yet: the entry can simply vanish.
    drop        = flush && ((state_q == ST_FWD) ||
                            ((state_q == ST_REQ) && !data_sram_addr_ok));
    // The request is already (or just now) accepted: keep the entry so the
    // memory stage drains the response, but mark it as a ghost.
    make_ghost  = flush && ((state_q == ST_ACC) ||
                            ((state_q == ST_REQ) && data_sram_addr_ok));
    capture     = ds_to_es_valid && es_allowin && !flush;
  end

  always_comb begin
    state_d   = state_q;
    ghost_d   = ghost_q || make_ghost;
    mem_en_d  = mem_en_q;
    mem_we_d  = mem_we_q;
    ale_d     = ale_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    payload_d = payload_q;
    if (capture) begin
      mem_en_d  = ds_mem_en;
      mem_we_d  = ds_mem_we;
      ale_d     = ds_mem_en && ds_ale_raw;
      size_d    = ds_mem_size;
      addr_d    = ds_addr;
      wstrb_d   = ds_mem_we ? ds_wstrb : '0;
      wdata_d   = ds_wdata;
      payload_d = ds_payload;
      ghost_d   = 1'b0;
      state_d   = (ds_mem_en && !ds_ale_raw) ? ST_REQ : ST_FWD;
    end else if (drop || handoff) begin
      state_d = ST_IDLE;
      ghost_d = 1'b0;
    end else if ((state_q == ST_REQ) && data_sram_addr_ok) begin
      state_d = ST_ACC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ghost_q   <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      ale_q     <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      ghost_q   <= ghost_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      ale_q     <= ale_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      payload_q <= payload_d;
    end
  end

  // A flush only withdraws req when the slave is not accepting in the same
  // cycle; an accepting cycle must still present req so the handshake holds.
  assign data_sram_req   = (state_q == ST_REQ) && (!flush || data_sram_addr_ok);
  assign data_sram_wr    = mem_we_q;
  assign data_sram_size  = size_q;
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wdata = wdata_q;

  assign es_to_ms_valid  = es_ready_go && !drop;

  always_comb begin
    es_to_ms_bus                              = '0;
    es_to_ms_bus[BUS_WE]                      = mem_we_q;
    es_to_ms_bus[BUS_EN]                      = mem_en_q;
    es_to_ms_bus[BUS_GHOST]                   = ghost_q || make_ghost;
    es_to_ms_bus[BUS_ALE]                     = ale_q;
    es_to_ms_bus[BUS_ADDR +: 32]              = addr_q;
    es_to_ms_bus[BUS_PAYLOAD +: PAYLOAD_W]    = payload_q;
  end

endmodule

// File: tb/tb_exe_lsu_stage.sv
// tb_exe_lsu_stage: directed and randomized checks of exe_lsu_stage.
// Instance a uses a 32-bit datapath, instance b a 64-bit one; both share all
// inputs (b sees the full 64-bit store data). Random traffic is checked on
// instance a against a one-entry reference model built from byte-lane rules.
module tb_exe_lsu_stage;
  import lsu_pkg::*;

  localparam int PW = 70;

  logic          clk = 1'b0;
  logic          reset;
  logic          ds_to_es_valid, ds_mem_en, ds_mem_we;
  logic [1:0]    ds_mem_size;
  logic [31:0]   ds_base, ds_offset;
  logic [63:0]   ds_st_data;
  logic [PW-1:0] ds_payload;
  logic          flush, ms_allowin, data_sram_addr_ok;

  logic          a_allowin, a_valid, a_req, a_wr;
  logic [PW+35:0] a_bus;
  logic [1:0]    a_size;
  logic [3:0]    a_wstrb;
  logic [31:0]   a_addr, a_wdata;

  logic          b_allowin, b_valid, b_req, b_wr;
  logic [PW+35:0] b_bus;
  logic [1:0]    b_size;
  logic [7:0]    b_wstrb;
  logic [31:0]   b_addr;
  logic [63:0]   b_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_lsu_stage #(.DATA_W(32), .PAYLOAD_W(PW)) u_dut_a (
    .clk(clk), .reset(reset), .ds_to_es_valid(ds_to_es_valid), .es_allowin(a_allowin),
    .ds_mem_en(ds_mem_en), .ds_mem_we(ds_mem_we), .ds_mem_size(ds_mem_size),
    .ds_base(ds_base), .ds_offset(ds_offset), .ds_st_data(ds_st_data[31:0]),
    .ds_payload(ds_payload), .flush(flush), .ms_allowin(ms_allowin),
    .es_to_ms_valid(a_valid), .es_to_ms_bus(a_bus), .data_sram_req(a_req),
    .data_sram_wr(a_wr), .data_sram_size(a_size), .data_sram_wstrb(a_wstrb),
    .data_sram_addr(a_addr), .data_sram_wdata(a_wdata), .data_sram_addr_ok(data_sram_addr_ok)
  );

  exe_lsu_stage #(.DATA_W(64), .PAYLOAD_W(PW)) u_dut_b (
    .clk(clk), .reset(reset), .ds_to_es_valid(ds_to_es_valid), .es_allowin(b_allowin),
    .ds_mem_en(ds_mem_en), .ds_mem_we(ds_mem_we), .ds_mem_size(ds_mem_size),
    .ds_base(ds_base), .ds_offset(ds_offset), .ds_st_data(ds_st_data),
    .ds_payload(ds_payload), .flush(flush), .ms_allowin(ms_allowin),
    .es_to_ms_valid(b_valid), .es_to_ms_bus(b_bus), .data_sram_req(b_req),
    .data_sram_wr(b_wr), .data_sram_size(b_size), .data_sram_wstrb(b_wstrb),
    .data_sram_addr(b_addr), .data_sram_wdata(b_wdata), .data_sram_addr_ok(data_sram_addr_ok)
  );

  typedef struct packed {
    logic          need_req;
    logic          acc;
    logic          en;
    logic          we;
    logic          ale;
    logic [1:0]    size;
    logic [31:0]   addr;
    logic [7:0]    wstrb;
    logic [63:0]   wdata;
    logic [PW-1:0] payload;
  } ent_t;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected entry from the current ds_* inputs, for a datapath of dw bits.
  function automatic ent_t make_ent(input int dw);
    ent_t e;
    int nbytes, lanes, off;
    logic [15:0] m;
    e         = '0;
    e.en      = ds_mem_en;
    e.we      = ds_mem_we;
    e.size    = ds_mem_size;
    e.payload = ds_payload;
    e.addr    = ds_base + ds_offset;
    nbytes    = 1 << ds_mem_size;
    lanes     = dw / 8;
    e.ale      = ds_mem_en && ((nbytes > lanes) || ((e.addr % nbytes) != 0));
    e.need_req = ds_mem_en && !e.ale;
    off       = int'(e.addr % lanes);
    m         = 16'((1 << nbytes) - 1) << off;
    e.wstrb   = ds_mem_we ? m[7:0] : 8'h00;
    for (int i = 0; i < lanes; i++)
      e.wdata[i*8 +: 8] = ds_st_data[(i % nbytes)*8 +: 8];
    return e;
  endfunction

  task automatic idle_inputs();
    ds_to_es_valid = 0; ds_mem_en = 0; ds_mem_we = 0; ds_mem_size = 2'd0;
    ds_base = 0; ds_offset = 0; ds_st_data = 0; ds_payload = '0;
    flush = 0; ms_allowin = 1; data_sram_addr_ok = 0;
  endtask

  task automatic present(input logic en, input logic we, input logic [1:0] sz,
                         input logic [31:0] base, input logic [31:0] off, input logic [63:0] d);
    ds_to_es_valid = 1; ds_mem_en = en; ds_mem_we = we; ds_mem_size = sz;
    ds_base = base; ds_offset = off; ds_st_data = d; ds_payload = PW'({base, off});
  endtask

  initial begin
    ent_t cur;
    logic cur_v, exp_ready, exp_req, exp_allow;
    logic [95:0] tmp96;
    int acc_cnt, txn;

    idle_inputs();
    reset = 1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid",   a_valid, 0);
    check("rst_req",     a_req, 0);
    check("rst_allowin", a_allowin, 1);
    check("rst_bus",     a_bus, 0);
    check("rst_addr",    a_addr, 0);
    check("rst_wstrb",   a_wstrb, 0);
    check("rst_wdata",   a_wdata, 0);
    @(negedge clk); reset = 0;

    // Store word, accepted in the first cycle, handed off at the next edge.
    present(1, 1, SZ_W, 32'h1000, 32'd4, 64'hA5A5_1234);
    @(negedge clk); ds_to_es_valid = 0; data_sram_addr_ok = 1; #1;
    check("sw_req", a_req, 1);
    check("sw_addr", a_addr, 32'h1004);
    check("sw_wstrb", a_wstrb, 4'hF);
    check("sw_wdata", a_wdata, 32'hA5A51234);
    check("sw_wr", a_wr, 1);
    check("sw_size", a_size, SZ_W);
    check("sw_valid", a_valid, 1);
    check("sw_allowin", a_allowin, 1);
    @(negedge clk); data_sram_addr_ok = 0; #1;
    check("sw_req_after", a_req, 0);
    check("sw_valid_after", a_valid, 0);
    $display("txn store word @1004 done");

    // Store byte at 0x1003.
    present(1, 1, SZ_B, 32'h1000, 32'd3, 64'h77);
    @(negedge clk); ds_to_es_valid = 0; data_sram_addr_ok = 1; #1;
    check("sb_addr", a_addr, 32'h1003);
    check("sb_wstrb", a_wstrb, 4'h8);
    check("sb_wdata", a_wdata, 32'h77777777);
    @(negedge clk); data_sram_addr_ok = 0;
    $display("txn store byte @1003 done");

    // Misaligned load half: forwarded with ale, no request.
    present(1, 0, SZ_H, 32'h2000, 32'd1, 64'h0);
    @(negedge clk); ds_to_es_valid = 0; #1;
    check("lh_req", a_req, 0);
    check("lh_valid", a_valid, 1);
    check("lh_ale", a_bus[BUS_ALE], 1);
    check("lh_addr_field", a_bus[BUS_ADDR +: 32], 32'h2001);
    @(negedge clk); #1;
    check("lh_valid_after", a_valid, 0);
    $display("txn load half @2001 ale done");

    // Load word with addr_ok delayed three cycles.
    present(1, 0, SZ_W, 32'h3000, 32'd8, 64'h0);
    acc_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); ds_to_es_valid = 0; #1;
      check("dly_req", a_req, 1);
      check("dly_addr", a_addr, 32'h3008);
      check("dly_allowin", a_allowin, 0);
      check("dly_valid", a_valid, 0);
      if (a_req && data_sram_addr_ok) acc_cnt++;
    end
    @(negedge clk); data_sram_addr_ok = 1; #1;
    check("dly_req_acc", a_req, 1);
    check("dly_addr_acc", a_addr, 32'h3008);
    check("dly_valid_acc", a_valid, 1);
    if (a_req && data_sram_addr_ok) acc_cnt++;
    @(negedge clk); #1;
    if (a_req && data_sram_addr_ok) acc_cnt++;
    data_sram_addr_ok = 0;
    check("dly_accept_count", acc_cnt, 1);
    check("dly_allowin_after", a_allowin, 1);
    $display("txn load word @3008 delayed done");

    // Flush in REQ without addr_ok: dropped.
    present(1, 0, SZ_W, 32'h4000, 32'd0, 64'h0);
    @(negedge clk); ds_to_es_valid = 0; flush = 1; #1;
    check("fl_req_gated", a_req, 0);
    check("fl_valid", a_valid, 0);
    @(negedge clk); flush = 0; #1;
    check("fl_req_after", a_req, 0);
    check("fl_valid_after", a_valid, 0);
    check("fl_allowin_after", a_allowin, 1);
    $display("txn load word @4000 flushed");

    // Flush in ACC: forwarded later as a ghost.
    present(1, 1, SZ_W, 32'h5000, 32'd0, 64'h1111);
    @(negedge clk); ds_to_es_valid = 0; data_sram_addr_ok = 1; ms_allowin = 0; #1;
    check("gh_req", a_req, 1);
    check("gh_allowin", a_allowin, 0);
    @(negedge clk); data_sram_addr_ok = 0; flush = 1; #1;
    check("gh_req_acc", a_req, 0);
    check("gh_valid_flush", a_valid, 1);
    check("gh_ghost_flush", a_bus[BUS_GHOST], 1);
    @(negedge clk); flush = 0; #1;
    check("gh_valid_hold", a_valid, 1);
    check("gh_ghost_hold", a_bus[BUS_GHOST], 1);
    @(negedge clk); flush = 1; ms_allowin = 1; #1;
    check("gh_valid_out", a_valid, 1);
    check("gh_ghost_out", a_bus[BUS_GHOST], 1);
    check("gh_allowin_out", a_allowin, 1);
    @(negedge clk); flush = 0; #1;
    check("gh_valid_after", a_valid, 0);
    $display("txn store word @5000 ghost done");

    // Back-to-back requests under continuous addr_ok.
    data_sram_addr_ok = 1;
    present(1, 1, SZ_W, 32'h6000, 32'd0, 64'h1);
    @(negedge clk); present(1, 1, SZ_H, 32'h6000, 32'd2, 64'hBEEF); #1;
    check("b2b_addr0", a_addr, 32'h6000);
    check("b2b_allowin0", a_allowin, 1);
    @(negedge clk); present(1, 0, SZ_B, 32'h6000, 32'd7, 64'h0); #1;
    check("b2b_addr1", a_addr, 32'h6002);
    check("b2b_wstrb1", a_wstrb, 4'hC);
    check("b2b_wdata1", a_wdata, 32'hBEEFBEEF);
    @(negedge clk); ds_to_es_valid = 0; #1;
    check("b2b_addr2", a_addr, 32'h6007);
    check("b2b_wstrb2", a_wstrb, 4'h0);
    check("b2b_req2", a_req, 1);
    @(negedge clk); data_sram_addr_ok = 0; #1;
    check("b2b_req_after", a_req, 0);
    $display("txn back-to-back x3 done");

    // Reset while a request is pending.
    present(1, 0, SZ_W, 32'h7000, 32'd0, 64'h0);
    @(negedge clk); ds_to_es_valid = 0; #1;
    check("rr_req", a_req, 1);
    reset = 1;
    @(negedge clk); #1;
    check("rr_req_after", a_req, 0);
    check("rr_valid_after", a_valid, 0);
    check("rr_allowin_after", a_allowin, 1);
    reset = 0;
    $display("txn reset in REQ done");

    // 64-bit datapath: byte at 0x1005 and an aligned dword.
    data_sram_addr_ok = 1;
    present(1, 1, SZ_B, 32'h1000, 32'd5, 64'h77);
    @(negedge clk); present(1, 1, SZ_D, 32'h1000, 32'd8, 64'h0123_4567_89AB_CDEF); #1;
    check("d64_sb_req", b_req, 1);
    check("d64_sb_addr", b_addr, 32'h1005);
    check("d64_sb_wstrb", b_wstrb, 8'h20);
    check("d64_sb_wdata", b_wdata, 64'h7777_7777_7777_7777);
    @(negedge clk); ds_to_es_valid = 0; #1;
    check("d64_sd_wstrb", b_wstrb, 8'hFF);
    check("d64_sd_wdata", b_wdata, 64'h0123_4567_89AB_CDEF);
    check("d64_sd_size", b_size, SZ_D);
    check("d32_sd_req", a_req, 0);
    check("d32_sd_ale", a_bus[BUS_ALE], 1);
    check("d32_sd_valid", a_valid, 1);
    @(negedge clk); data_sram_addr_ok = 0;
    $display("txn 64-bit byte/dword stores done");

    // Randomized traffic on the 32-bit instance against the reference model.
    reset = 1;
    @(negedge clk); @(negedge clk); reset = 0;
    cur = '0; cur_v = 0; txn = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      ds_to_es_valid = ($urandom_range(0, 3) != 0);
      ds_mem_en      = ($urandom_range(0, 3) != 0);
      ds_mem_we      = ds_mem_en && ($urandom_range(0, 1) == 1);
      ds_mem_size    = 2'($urandom_range(0, 3));
      ds_base        = $urandom;
      ds_offset      = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        ds_base[1:0] = 2'b00; ds_offset[1:0] = 2'b00;
      end
      ds_st_data     = {$urandom, $urandom};
      tmp96          = {$urandom, $urandom, $urandom};
      ds_payload     = tmp96[PW-1:0];
      data_sram_addr_ok = ($urandom_range(0, 1) == 1);
      ms_allowin     = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = cur_v && (!cur.need_req || cur.acc || data_sram_addr_ok);
      exp_req   = cur_v && cur.need_req && !cur.acc;
      exp_allow = !cur_v || (exp_ready && ms_allowin);
      check("rnd_req", a_req, exp_req);
      check("rnd_valid", a_valid, exp_ready);
      check("rnd_allowin", a_allowin, exp_allow);
      if (exp_req) begin
        check("rnd_addr", a_addr, cur.addr);
        check("rnd_wstrb", a_wstrb, cur.wstrb[3:0]);
        check("rnd_wdata", a_wdata, cur.wdata[31:0]);
        check("rnd_wr", a_wr, cur.we);
        check("rnd_size", a_size, cur.size);
      end
      if (exp_ready)
        check("rnd_bus", a_bus, {cur.payload, cur.addr, cur.ale, 1'b0, cur.en, cur.we});
      if (exp_req && data_sram_addr_ok) cur.acc = 1'b1;
      if (exp_ready && ms_allowin) begin
        txn++;
        $display("txn %0d en=%0d we=%0d size=%0d addr=%h ale=%0d", txn, cur.en, cur.we,
                 cur.size, cur.addr, cur.ale);
        cur_v = 1'b0;
      end
      if (ds_to_es_valid && exp_allow) begin
        cur   = make_ent(32);
        cur_v = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
